mix_state_reader: RTL and testbench
===================================

# mix_state_reader

Consumer end of the 8-lane mixing datapath: accepts a full 8×32-bit state snapshot (lanes o0..o7) through a valid/ready handshake and streams it out one word per beat on a valid/ready word port. After the eight state words it appends a checksum beat flagged `out_last`. It is the readout path used to observe mix-core state from a testbench or a host-side serial link without stalling the core for more than one capture cycle.

## Interface
Parameters:
- `WORD_W`, 32: lane width in bits.
- `N_WORDS`, 8: lanes per snapshot. Frame length is `N_WORDS+1` beats.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `snap_valid`  in  1  snapshot offered.
- `snap_ready`  out  1  high only in IDLE and not in reset.
- `snap_data`  in  N_WORDS*WORD_W  lane i at bits [i*WORD_W +: WORD_W].
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  downstream accepts beat.
- `out_data`  out  WORD_W  lane word, or checksum on the last beat.
- `out_idx`  out  4  beat index, 0..N_WORDS.
- `out_last`  out  1  high on the checksum beat only.
- `frame_cnt`  out  16  completed frames, wraps.

## Operation
- States: IDLE, SEND, SUM.
- IDLE:
  - `snap_ready=1`.
  - When `snap_valid && snap_ready`, latch `snap_data` into an internal buffer, clear the accumulator, set idx=0, and go to SEND.
- SEND:
  - `out_valid=1`, `out_data=buf[idx]`, `out_idx=idx`, `out_last=0`.
  - On an out handshake: `acc += rotl(buf[idx], idx)` (mod 2^WORD_W) and idx++.
  - Handshake on idx=N_WORDS-1 goes to SUM.
- SUM:
  - `out_valid=1`, `out_data=acc`, `out_idx=N_WORDS`, `out_last=1`.
  - On handshake: `frame_cnt++` (0xFFFF wraps to 0) and go to IDLE.
- Arithmetic:
  - `rotl(x,k)` rotates left by k mod WORD_W.
  - All sums are unsigned and truncated to WORD_W.
- `snap_valid` outside IDLE is ignored. `snap_data` is sampled only at the capture edge, so later changes do not affect the frame in flight.

## Timing
- Reset values: `snap_ready=0` while `rst` is high; `out_valid=0`, `out_data=0`, `out_idx=0`, `out_last=0`, `frame_cnt=0`, state IDLE. `snap_ready` rises in the first cycle after `rst` falls.
- Capture at edge N gives `out_valid=1` with beat 0 in cycle N+1. There is no combinational path from `snap_*` to `out_*`.
- `out_ready` is a don't-care while `out_valid=0`.
- With `out_ready` held high, beats 0..8 appear in cycles N+1..N+9 and `snap_ready` returns in cycle N+10. Frame period is 10 cycles.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_idx` and `out_last` hold stable. `out_valid` never drops mid-frame.
- `frame_cnt` updates at the edge that accepts the last beat.
- Reset mid-frame:
  - The frame is aborted and no `out_last` is emitted.
  - `out_valid` is 0 in the cycle after the reset edge.
  - `frame_cnt` is cleared.
- Simultaneous `snap_valid` and a last-beat handshake: the snapshot is not taken, because `snap_ready=0` in SUM. It is accepted on the next cycle if still offered.

## Structure
- Shared package `mix_pkg` holds:
  - `WORD_W` and `N_WORDS` default constants;
  - the state enum (IDLE, SEND, SUM);
  - the `rotl` function, reused by the mix-core reference model.
- One sub-module, `mix_csum_acc`: the rotate-add accumulator with `clr`, `en`, `word`, `idx` inputs and an `acc` output. It is reused by the bench scoreboard.
- Snapshot buffer and beat index stay in the top module.

## Test plan
- Reset, then snapshot {o0..o7}={0,1,...,7} with `out_ready=1`:
  - beats 0..7 carry 0..7;
  - beat 8 carries 0x00000602 with `out_last=1`;
  - `frame_cnt=1`; `snap_ready` returns 10 cycles after capture.
- Same snapshot with `out_ready` toggling 1,0,0,1,...: identical beat sequence; data held stable while stalled; no beat dropped or duplicated.
- All lanes 0x80000001: lane i rotates to a known value and the checksum equals the bench sum mod 2^32, which checks rotate wrap-around.
- `snap_valid` held high continuously with `out_ready=1`: captures occur every 10 cycles. Changing `snap_data` mid-frame does not alter beats in flight.
- Assert `rst` at beat 4: `out_valid=0` the next cycle, no `out_last` seen, `frame_cnt=0`, `snap_ready=1` the cycle after `rst` falls.
- Preload `frame_cnt` to 0xFFFE (by running 65534 frames, or via a force in a short bench), then complete 2 frames: `frame_cnt` reads 0x0000.

Source files
------------

// File: rtl/mix_pkg.sv
// Shared definitions for the 8-lane mix datapath: lane geometry, reader FSM states
// and the rotate helper shared with the mix-core reference model.
package mix_pkg;

  localparam int WORD_W  = 32;
  localparam int N_WORDS = 8;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    SUM
  } reader_state_e;

  // Rotate left by k mod WORD_W; the doubled word keeps k=0 free of an oversized shift.
  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x,
                                             input logic [31:0]       k);
    logic [2*WORD_W-1:0] dbl;
    dbl = {x, x} << (k % WORD_W);
    return dbl[2*WORD_W-1 -: WORD_W];
  endfunction

endpackage

// File: rtl/mix_state_reader_if.sv
// Snapshot-in / word-stream-out bundle of the mix state reader.
// The master side offers snapshots and sinks beats; the slave side is the reader.
interface mix_state_reader_if #(
  parameter int WORD_W  = mix_pkg::WORD_W,
  parameter int N_WORDS = mix_pkg::N_WORDS
);

  logic                         snap_valid;
  logic                         snap_ready;
  logic [N_WORDS*WORD_W-1:0]    snap_data;

  logic                         out_valid;
  logic                         out_ready;
  logic [WORD_W-1:0]            out_data;
  logic [mix_pkg::IDX_W-1:0]    out_idx;
  logic                         out_last;
  logic [mix_pkg::CNT_W-1:0]    frame_cnt;

  modport master (
    output snap_valid, snap_data, out_ready,
    input  snap_ready, out_valid, out_data, out_idx, out_last, frame_cnt
  );

  modport slave (
    input  snap_valid, snap_data, out_ready,
    output snap_ready, out_valid, out_data, out_idx, out_last, frame_cnt
  );

endinterface

// File: rtl/mix_csum_acc.sv
// Rotate-add checksum accumulator: acc += rotl(word, idx) on each enabled cycle.
// clr has priority over en so a fresh frame always starts from zero.
module mix_csum_acc #(
  parameter int WORD_W = mix_pkg::WORD_W,
  parameter int IDX_W  = mix_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [WORD_W-1:0] word,
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] acc
);

  import mix_pkg::rotl;

  logic [WORD_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + rotl(word, 32'(idx));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mix_state_reader.sv
// Mix-core state readout: captures an N_WORDS-lane snapshot in one cycle, then streams
// it a word per beat, followed by a rotate-add checksum beat flagged out_last.
module mix_state_reader #(
  parameter int WORD_W  = mix_pkg::WORD_W,
  parameter int N_WORDS = mix_pkg::N_WORDS
) (
  input logic               clk,
  input logic               rst,
  mix_state_reader_if.slave bus
);

  import mix_pkg::IDX_W, mix_pkg::CNT_W;
  import mix_pkg::reader_state_e, mix_pkg::IDLE, mix_pkg::SEND, mix_pkg::SUM;

  localparam int SEL_W = $clog2(N_WORDS);

  reader_state_e     state_q, state_d;
  logic [WORD_W-1:0] buf_q [N_WORDS];
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] cur_word;
  logic              snap_fire;
  logic              out_fire;
  logic              send_fire;
  logic              last_lane;

  assign snap_fire = bus.snap_valid && bus.snap_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign send_fire = (state_q == SEND) && out_fire;
  assign cur_word  = buf_q[idx_q[SEL_W-1:0]];
  assign last_lane = (idx_q == IDX_W'(N_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (snap_fire)              state_d = SEND;
      SEND:    if (out_fire && last_lane)  state_d = SUM;
      SUM:     if (out_fire)               state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Outputs are decoded from registered state only, so nothing on snap_* reaches out_*.
  always_comb begin
    bus.snap_ready = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_data   = '0;
    bus.out_idx    = '0;
    bus.out_last   = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.snap_ready = !rst;
      end
      SEND: begin
        bus.out_valid = 1'b1;
        bus.out_data  = cur_word;
        bus.out_idx   = idx_q;
      end
      SUM: begin
        bus.out_valid = 1'b1;
        bus.out_data  = acc;
        bus.out_idx   = IDX_W'(N_WORDS);
        bus.out_last  = 1'b1;
      end
      default: begin
        bus.snap_ready = 1'b0;
      end
    endcase
  end

  assign bus.frame_cnt = frame_cnt_q;

  always_comb begin
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    if (snap_fire) begin
      idx_d = '0;
    end else if (send_fire) begin
      idx_d = idx_q + IDX_W'(1);
    end
    if ((state_q == SUM) && out_fire) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // The buffer needs no reset: it is only read after a capture has filled it.
  always_ff @(posedge clk) begin
    if (snap_fire) begin
      for (int i = 0; i < N_WORDS; i++) begin
        buf_q[i] <= bus.snap_data[i*WORD_W +: WORD_W];
      end
    end
  end

  mix_csum_acc #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_csum (
    .clk  (clk),
    .rst  (rst),
    .clr  (snap_fire),
    .en   (send_fire),
    .word (cur_word),
    .idx  (idx_q),
    .acc  (acc)
  );

endmodule

// File: tb/tb_mix_state_reader.sv
// Scoreboard bench for mix_state_reader: expected beats are queued at capture time
// and compared as the reader hands them over.
module tb_mix_state_reader;

  localparam int W = 32;
  localparam int N = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic [3:0]   idx;
    logic         last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_frames = '0;
  beat_t       sb[$];

  mix_state_reader_if #(.WORD_W(W), .N_WORDS(N)) bus ();

  mix_state_reader #(.WORD_W(W), .N_WORDS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_rotl(input logic [W-1:0] x, input int k);
    int s;
    s = k % W;
    if (s == 0) return x;
    return (x << s) | (x >> (W - s));
  endfunction

  task automatic push_frame(input logic [N*W-1:0] snap);
    logic [W-1:0] word;
    logic [W-1:0] sum;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      word = snap[i*W +: W];
      sb.push_back({word, 4'(i), 1'b0});
      sum = sum + ref_rotl(word, i);
    end
    sb.push_back({sum, 4'(N), 1'b1});
  endtask

  // Called at a negedge; returns at the negedge right after the capture edge.
  task automatic start_capture(input logic [N*W-1:0] snap, input bit hold, output int cap);
    bit got;
    got = 1'b0;
    cap = cyc;
    bus.snap_valid = 1'b1;
    bus.snap_data  = snap;
    for (int n = 0; n < 40 && !got; n++) begin
      if (bus.snap_ready === 1'b1) begin
        got = 1'b1;
        cap = cyc;
        push_frame(snap);
      end
      @(negedge clk);
    end
    if (!hold) bus.snap_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL capture_timeout: snap_ready never high within 40 cycles");
    end
  endtask

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating.
  task automatic collect_frame(input int mode, input int cap);
    bit    done, held, abort;
    beat_t held_b, obs, exp_b;
    done = 1'b0; held = 1'b0; abort = 1'b0;
    for (int n = 0; n < 80 && !done && !abort; n++) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      obs = {bus.out_data, bus.out_idx, bus.out_last};
      if (n == 0) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL first_beat_latency: out_valid=%b want 1 one cycle after capture", bus.out_valid);
        end
      end
      if (bus.out_valid === 1'b1) begin
        if (held) begin
          checks++;
          if (obs !== held_b) begin
            errors++;
            $display("[TB] FAIL stall_hold: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                     obs.data, obs.idx, obs.last, held_b.data, held_b.idx, held_b.last);
          end
        end
        if (bus.out_ready) begin
          held = 1'b0;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            abort = 1'b1;
            $display("[TB] FAIL extra_beat: got data=%h idx=%0d with nothing expected", obs.data, obs.idx);
          end else begin
            exp_b = sb.pop_front();
            if (obs !== exp_b) begin
              errors++;
              $display("[TB] FAIL beat: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                       obs.data, obs.idx, obs.last, exp_b.data, exp_b.idx, exp_b.last);
            end
            if (exp_b.last) done = 1'b1;
          end
          if (done && mode == 0) begin
            checks++;
            if (bus.snap_ready !== 1'b0 || cyc != cap + 9) begin
              errors++;
              $display("[TB] FAIL last_beat_timing: snap_ready=%b cycle=%0d want 0 at cycle %0d",
                       bus.snap_ready, cyc - cap, 9);
            end
          end
        end else begin
          held   = 1'b1;
          held_b = obs;
        end
      end else begin
        checks++;
        errors++;
        abort = 1'b1;
        $display("[TB] FAIL valid_drop: out_valid=0 mid-frame, %0d beats still expected", sb.size());
      end
      @(negedge clk);
    end
    if (!done && !abort) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_timeout: %0d beats still outstanding", sb.size());
    end
    sb.delete();
  endtask

  task automatic check_after_frame(input string name);
    exp_frames = exp_frames + 16'd1;
    checks++;
    if (bus.frame_cnt !== exp_frames) begin
      errors++;
      $display("[TB] FAIL %s_frame_cnt: got %h want %h", name, bus.frame_cnt, exp_frames);
    end
    checks++;
    if (bus.snap_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_ready_return: snap_ready=%b want 1", name, bus.snap_ready);
    end
  endtask

  function automatic logic [N*W-1:0] ramp_snap();
    logic [N*W-1:0] s;
    for (int i = 0; i < N; i++) s[i*W +: W] = W'(i);
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.snap_valid = 1'b1;
    bus.snap_data  = '1;
    bus.out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.snap_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_snap_ready: got %b want 0", bus.snap_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h want 0", bus.out_data); end
    checks++;
    if (bus.out_idx !== 4'd0 || bus.out_last !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idx_last: got idx=%0d last=%b want 0/0", bus.out_idx, bus.out_last);
    end
    checks++;
    if (bus.frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %h want 0", bus.frame_cnt); end
    bus.snap_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.snap_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: snap_ready=%b out_valid=%b want 1/0", bus.snap_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    int cap;
    start_capture(ramp_snap(), 1'b0, cap);
    collect_frame(0, cap);
    check_after_frame("basic");
  endtask

  task automatic test_backpressure();
    int cap;
    start_capture(ramp_snap(), 1'b0, cap);
    collect_frame(1, cap);
    check_after_frame("stall");
  endtask

  task automatic test_rotate_wrap();
    int             cap;
    logic [N*W-1:0] s;
    for (int i = 0; i < N; i++) s[i*W +: W] = 32'h8000_0001;
    start_capture(s, 1'b0, cap);
    collect_frame(0, cap);
    check_after_frame("rotwrap");
  endtask

  task automatic test_back_to_back();
    int             cap1, cap2;
    logic [N*W-1:0] a, b;
    for (int i = 0; i < N; i++) begin
      a[i*W +: W] = 32'hA000_0000 | W'(i * 17);
      b[i*W +: W] = $urandom;
    end
    start_capture(a, 1'b1, cap1);
    bus.snap_data = ~a;
    collect_frame(0, cap1);
    check_after_frame("b2b_first");
    start_capture(b, 1'b1, cap2);
    bus.snap_data = '0;
    checks++;
    if (cap2 - cap1 != 10) begin
      errors++;
      $display("[TB] FAIL b2b_period: got %0d cycles want 10", cap2 - cap1);
    end
    collect_frame(0, cap2);
    bus.snap_valid = 1'b0;
    check_after_frame("b2b_second");
  endtask

  task automatic test_reset_mid_frame();
    int cap;
    bit seen, last_seen;
    seen = 1'b0; last_seen = 1'b0;
    start_capture(ramp_snap(), 1'b0, cap);
    bus.out_ready = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (bus.out_last === 1'b1) last_seen = 1'b1;
      if (bus.out_valid === 1'b1 && bus.out_idx === 4'd4) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL midrst_beat4: beat 4 never presented"); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.snap_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs: out_valid=%b snap_ready=%b want 0/0", bus.out_valid, bus.snap_ready);
    end
    checks++;
    if (bus.frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL midrst_frame_cnt: got %h want 0", bus.frame_cnt); end
    rst = 1'b0;
    @(negedge clk);
    if (bus.out_last === 1'b1) last_seen = 1'b1;
    checks++;
    if (bus.snap_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_release: snap_ready=%b out_valid=%b want 1/0", bus.snap_ready, bus.out_valid);
    end
    checks++;
    if (last_seen) begin errors++; $display("[TB] FAIL midrst_last: out_last seen=1 want 0"); end
    sb.delete();
    exp_frames = '0;
  endtask

  task automatic test_counter_wrap();
    int             cap;
    logic [N*W-1:0] s;
    force dut.frame_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    exp_frames = 16'hFFFE;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) s[i*W +: W] = $urandom;
      start_capture(s, 1'b0, cap);
      collect_frame(f, cap);
      check_after_frame(f == 0 ? "wrap_ffff" : "wrap_0000");
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    bus.snap_valid = 1'b0;
    bus.snap_data  = '0;
    bus.out_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_rotate_wrap();
    test_back_to_back();
    test_reset_mid_frame();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
